// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and width helpers for the convolution sequencer
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Degenerate sizes still need a one-bit port.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_w(input int size);
        return clog2_min1(size * size);
    endfunction

    function automatic int kaddr_w(input int ker);
        return clog2_min1(ker * ker);
    endfunction

    function automatic int idx_w(input int size);
        return clog2_min1(size);
    endfunction

endpackage

// File: rtl/conv2_idx_counter.sv
// rtl/conv2_idx_counter.sv - two-level wrapping index counter with look-ahead next values
module conv2_idx_counter #(
    parameter int W         = 2,
    parameter int INNER_MAX = 2,
    parameter int OUTER_MAX = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] inner,
    output logic [W-1:0] outer,
    output logic [W-1:0] inner_nxt,
    output logic [W-1:0] outer_nxt,
    output logic         wrap
);

    localparam logic [W-1:0] IMAX = W'(INNER_MAX);
    localparam logic [W-1:0] OMAX = W'(OUTER_MAX);

    // Set on the terminal count, i.e. the next inc returns both levels to zero.
    assign wrap = (inner == IMAX) && (outer == OMAX);

    always_comb begin
        inner_nxt = inner;
        outer_nxt = outer;
        if (clr) begin
            inner_nxt = '0;
            outer_nxt = '0;
        end else if (inc) begin
            if (inner == IMAX) begin
                inner_nxt = '0;
                outer_nxt = (outer == OMAX) ? '0 : outer + 1'b1;
            end else begin
                inner_nxt = inner + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inner <= '0;
            outer <= '0;
        end else begin
            inner <= inner_nxt;
            outer <= outer_nxt;
        end
    end

endmodule

// File: rtl/conv2_window_sched.sv
// rtl/conv2_window_sched.sv - output/tap walker driving buffer reads and MAC control for 2-D valid convolution
module conv2_window_sched
    import conv_pkg::*;
#(
    parameter  int SIZE      = 320,
    parameter  int SIZEKer   = 3,
    parameter  int WIDTH_BIT = 16,
    localparam int ADDR_W    = addr_w(SIZE),
    localparam int KADDR_W   = kaddr_w(SIZEKer),
    localparam int IDX_W     = idx_w(SIZE)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  img_addr,
    output logic [KADDR_W-1:0] ker_addr,
    output logic               mac_clr,
    output logic               mac_en,
    output logic               mac_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_row,
    output logic [IDX_W-1:0]   out_col
);

    localparam int OUT_N = SIZE - SIZEKer + 1;

    if (SIZEKer < 1 || SIZEKer > SIZE || WIDTH_BIT < 1) begin : g_bad_params
        $error("conv2_window_sched: unsupported SIZE/SIZEKer/WIDTH_BIT combination");
    end

    state_t state, state_n;

    logic             tap_inc, out_inc, cnt_clr;
    logic             tap_wrap, out_wrap, tap_first;
    logic [IDX_W-1:0] ki, kj, ki_n, kj_n;
    logic [IDX_W-1:0] r, c, r_n, c_n;

    logic [ADDR_W-1:0]  img_addr_n;
    logic [KADDR_W-1:0] ker_addr_n;

    conv2_idx_counter #(
        .W         (IDX_W),
        .INNER_MAX (SIZEKer - 1),
        .OUTER_MAX (SIZEKer - 1)
    ) u_tap_cnt (
        .clock     (clock),
        .reset     (reset),
        .clr       (cnt_clr),
        .inc       (tap_inc),
        .inner     (kj),
        .outer     (ki),
        .inner_nxt (kj_n),
        .outer_nxt (ki_n),
        .wrap      (tap_wrap)
    );

    conv2_idx_counter #(
        .W         (IDX_W),
        .INNER_MAX (OUT_N - 1),
        .OUTER_MAX (OUT_N - 1)
    ) u_out_cnt (
        .clock     (clock),
        .reset     (reset),
        .clr       (cnt_clr),
        .inc       (out_inc),
        .inner     (c),
        .outer     (r),
        .inner_nxt (c_n),
        .outer_nxt (r_n),
        .wrap      (out_wrap)
    );

    assign tap_first = (ki == '0) && (kj == '0);

    always_comb begin
        state_n = state;
        tap_inc = 1'b0;
        out_inc = 1'b0;
        cnt_clr = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n = ST_RUN;
                    cnt_clr = 1'b1;
                end
            end
            ST_RUN: begin
                tap_inc = 1'b1;
                if (tap_wrap) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_n = ST_WRITE;
            end
            ST_WRITE: begin
                if (out_ready) begin
                    out_inc = 1'b1;
                    state_n = out_wrap ? ST_DONE : ST_RUN;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign rd_en     = (state == ST_RUN);
    assign out_valid = (state == ST_WRITE);
    assign busy      = (state == ST_RUN) || (state == ST_DRAIN) || (state == ST_WRITE);
    assign done      = (state == ST_DONE);
    assign out_row   = r;
    assign out_col   = c;

    // Addresses are built from the counters' next values so the registered
    // copy lines up with the tap being read; idle cycles simply hold.
    always_comb begin
        img_addr_n = (ADDR_W'(r_n) + ADDR_W'(ki_n)) * ADDR_W'(SIZE)
                   + ADDR_W'(c_n) + ADDR_W'(kj_n);
        ker_addr_n = KADDR_W'(ki_n) * KADDR_W'(SIZEKer) + KADDR_W'(kj_n);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            img_addr <= '0;
            ker_addr <= '0;
            mac_en   <= 1'b0;
            mac_clr  <= 1'b0;
            mac_last <= 1'b0;
        end else begin
            state    <= state_n;
            img_addr <= img_addr_n;
            ker_addr <= ker_addr_n;
            // Buffer data arrives one cycle after rd_en.
            mac_en   <= rd_en;
            mac_clr  <= rd_en && tap_first;
            mac_last <= rd_en && tap_wrap;
        end
    end

endmodule

// File: tb/tb_conv2_window_sched.sv
// tb/tb_conv2_window_sched.sv - scoreboard bench for conv2_window_sched at SIZE=4, SIZEKer=3
module tb_conv2_window_sched;

    localparam int SIZE   = 4;
    localparam int KER    = 3;
    localparam int OUT_N  = SIZE - KER + 1;
    localparam int KK     = KER * KER;
    localparam int RUN_CY = OUT_N * OUT_N * (KK + 2) + 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       busy, done, rd_en;
    logic [3:0] img_addr;
    logic [3:0] ker_addr;
    logic       mac_clr, mac_en, mac_last;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_row, out_col;

    conv2_window_sched #(
        .SIZE      (SIZE),
        .SIZEKer   (KER),
        .WIDTH_BIT (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .img_addr  (img_addr),
        .ker_addr  (ker_addr),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .mac_last  (mac_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;
    int c0 = 0;
    int mac_idx = 0;
    int exp_img[$];
    int exp_ker[$];
    int exp_row[$];
    int exp_col[$];
    int ei, ek, er, ec;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_run();
        for (int r = 0; r < OUT_N; r++)
            for (int c = 0; c < OUT_N; c++) begin
                for (int ki = 0; ki < KER; ki++)
                    for (int kj = 0; kj < KER; kj++) begin
                        exp_img.push_back((r + ki) * SIZE + c + kj);
                        exp_ker.push_back(ki * KER + kj);
                    end
                exp_row.push_back(r);
                exp_col.push_back(c);
            end
    endtask

    task automatic flush_sb();
        exp_img.delete();
        exp_ker.delete();
        exp_row.delete();
        exp_col.delete();
        mac_idx = 0;
    endtask

    task automatic kick();
        start = 1'b1;
        step(1);
        start = 1'b0;
        c0 = cyc_cnt;
    endtask

    task automatic wait_done(output int n);
        int k;
        k = 0;
        while (!done && k < 300) begin
            step(1);
            k++;
        end
        if (!done) check_eq("done_timeout", 0, 1);
        n = cyc_cnt - c0 + 1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_rd_en"}, rd_en, 0);
        check_eq({tag, "_img"}, img_addr, 0);
        check_eq({tag, "_ker"}, ker_addr, 0);
        check_eq({tag, "_mac"}, {mac_en, mac_clr, mac_last}, 0);
        check_eq({tag, "_valid"}, out_valid, 0);
        check_eq({tag, "_rowcol"}, {out_row, out_col}, 0);
    endtask

    task automatic check_sb_empty(input string tag);
        check_eq({tag, "_addr_left"}, exp_img.size(), 0);
        check_eq({tag, "_out_left"}, exp_row.size(), 0);
    endtask

    always @(negedge clock) begin
        if (rd_en) begin
            if (exp_img.size() == 0) begin
                check_eq("rd_unexpected", 1, 0);
            end else begin
                ei = exp_img.pop_front();
                ek = exp_ker.pop_front();
                check_eq("img_addr", img_addr, ei);
                check_eq("ker_addr", ker_addr, ek);
            end
        end
        if (mac_en) begin
            check_eq("mac_clr", mac_clr, (mac_idx == 0) ? 1 : 0);
            check_eq("mac_last", mac_last, (mac_idx == KK - 1) ? 1 : 0);
            if (mac_last) check_eq("mac_last_in_drain", rd_en, 0);
            mac_idx = (mac_idx == KK - 1) ? 0 : mac_idx + 1;
        end
        if (out_valid && out_ready) begin
            if (exp_row.size() == 0) begin
                check_eq("out_unexpected", 1, 0);
            end else begin
                er = exp_row.pop_front();
                ec = exp_col.pop_front();
                check_eq("out_row", out_row, er);
                check_eq("out_col", out_col, ec);
            end
        end
    end

    initial begin
        int n;
        int held_addr;
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        step(3);
        check_idle("reset");
        reset = 1'b0;
        step(1);
        check_idle("idle");

        // full run with a start pulse landing mid-run
        out_ready = 1'b1;
        push_run();
        kick();
        check_eq("busy_first_run", busy, 1);
        step(20);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(n);
        check_eq("done_cycle_run1", n, RUN_CY);
        check_eq("busy_after_done", busy, 0);
        step(2);
        check_eq("done_level", done, 1);
        check_sb_empty("run1");

        // restart from DONE with backpressure on the first output
        out_ready = 1'b0;
        push_run();
        kick();
        check_eq("done_cleared", done, 0);
        check_eq("busy_restart", busy, 1);
        check_eq("restart_img", img_addr, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            step(1);
            n++;
        end
        check_eq("first_write_cycle", cyc_cnt - c0 + 1, KK + 2);
        held_addr = img_addr;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", out_valid, 1);
            check_eq("bp_rd_en", rd_en, 0);
            check_eq("bp_rowcol", {out_row, out_col}, 0);
            check_eq("bp_addr_hold", img_addr, held_addr);
            step(1);
        end
        out_ready = 1'b1;
        wait_done(n);
        check_eq("done_cycle_bp", n, RUN_CY + 5);
        check_sb_empty("run2");

        // abort on tap 4 of pixel (0,1), with start asserted alongside reset
        push_run();
        kick();
        step(KK + 2 + 4);
        check_eq("tap4_addr", img_addr, SIZE + 1 + 1);
        check_eq("tap4_rowcol", {out_row, out_col}, 1);
        reset = 1'b1;
        start = 1'b1;
        step(1);
        flush_sb();
        check_idle("abort");
        reset = 1'b0;
        start = 1'b0;
        step(2);
        check_idle("post_abort");

        push_run();
        kick();
        wait_done(n);
        check_eq("done_cycle_rerun", n, RUN_CY);
        check_sb_empty("run3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
